// File: rtl/jump_pkg.sv
// Shared constants and types for the jump game scene renderer.
package jump_pkg;

   localparam int COORD_W = 10;
   localparam int SIZE_W  = 8;

   localparam int DEF_PLAYER_W  = 16;
   localparam int DEF_PLAT_H    = 8;
   localparam int DEF_GROUND_Y  = 440;
   localparam int DEF_BLINK_BIT = 4;

   localparam logic [COORD_W-1:0] RST_PX = 10'd312;

   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } rgb_t;

   localparam rgb_t COL_PLAYER = '{r: 4'hF, g: 4'hF, b: 4'h0};
   localparam rgb_t COL_PLAT   = '{r: 4'h0, g: 4'hC, b: 4'h0};
   localparam rgb_t COL_GROUND = '{r: 4'h8, g: 4'h4, b: 4'h0};
   localparam rgb_t COL_SKY    = '{r: 4'h3, g: 4'h9, b: 4'hF};

   typedef enum logic {
      ST_IDLE,
      ST_PENDING
   } upd_state_e;

   // One complete scene description as posted by the game logic.
   typedef struct packed {
      logic [COORD_W-1:0] px;
      logic [COORD_W-1:0] py;
      logic [COORD_W-1:0] p0_x;
      logic [COORD_W-1:0] p0_y;
      logic [SIZE_W-1:0]  p0_w;
      logic [COORD_W-1:0] p1_x;
      logic [COORD_W-1:0] p1_y;
      logic [SIZE_W-1:0]  p1_w;
      logic               go;
   } scene_t;

endpackage

// File: rtl/jump_scene_renderer_rect_hit.sv
// Combinational point-in-rectangle test; a zero width means the rectangle is hidden.
module rect_hit
   import jump_pkg::*;
(
   input  logic [COORD_W-1:0] x,
   input  logic [COORD_W-1:0] y,
   input  logic [COORD_W-1:0] rx,
   input  logic [COORD_W-1:0] ry,
   input  logic [SIZE_W-1:0]  rw,
   input  logic [SIZE_W-1:0]  rh,
   output logic               hit
);

   // One extra bit so that right/bottom edges never wrap around.
   logic [COORD_W:0] x_ext;
   logic [COORD_W:0] y_ext;
   logic [COORD_W:0] left;
   logic [COORD_W:0] top;
   logic [COORD_W:0] right;
   logic [COORD_W:0] bottom;

   assign x_ext  = {1'b0, x};
   assign y_ext  = {1'b0, y};
   assign left   = {1'b0, rx};
   assign top    = {1'b0, ry};
   assign right  = left + {{(COORD_W+1-SIZE_W){1'b0}}, rw};
   assign bottom = top  + {{(COORD_W+1-SIZE_W){1'b0}}, rh};

   // Half-open interval test on both axes.
   always_comb begin
      hit = (rw != '0) && (rh != '0) &&
            (x_ext >= left) && (x_ext < right) &&
            (y_ext >= top)  && (y_ext < bottom);
   end

endmodule

// File: rtl/jump_scene_renderer.sv
// Scene pixel source: double-buffered object registers committed at frame start,
// blinking game-over player, and a fixed-priority colour mux.
module jump_scene_renderer
   import jump_pkg::*;
#(
   parameter int PLAYER_W  = DEF_PLAYER_W,
   parameter int PLAT_H    = DEF_PLAT_H,
   parameter int GROUND_Y  = DEF_GROUND_Y,
   parameter int BLINK_BIT = DEF_BLINK_BIT
)(
   input  logic               clk_vga,
   input  logic               rst_vga,
   input  logic [COORD_W-1:0] i_x,
   input  logic [COORD_W-1:0] i_y,
   input  logic               i_vs,
   input  logic               i_upd_valid,
   output logic               o_upd_ready,
   input  logic [COORD_W-1:0] i_px,
   input  logic [COORD_W-1:0] i_py,
   input  logic [COORD_W-1:0] i_p0_x,
   input  logic [COORD_W-1:0] i_p0_y,
   input  logic [SIZE_W-1:0]  i_p0_w,
   input  logic [COORD_W-1:0] i_p1_x,
   input  logic [COORD_W-1:0] i_p1_y,
   input  logic [SIZE_W-1:0]  i_p1_w,
   input  logic               i_game_over,
   output logic [3:0]         o_r,
   output logic [3:0]         o_g,
   output logic [3:0]         o_b
);

   localparam scene_t ACTIVE_RST = '{
      px:   RST_PX,
      py:   COORD_W'(GROUND_Y - PLAYER_W),
      p0_x: '0, p0_y: '0, p0_w: '0,
      p1_x: '0, p1_y: '0, p1_w: '0,
      go:   1'b0
   };

   logic       vs_q;
   logic       frm_sof;
   upd_state_e state_q, state_d;
   scene_t     stage_q, stage_d;
   scene_t     active_q, active_d;
   scene_t     payload;
   logic [5:0] frame_cnt_q;
   logic       xfer;

   assign frm_sof     = vs_q & ~i_vs;
   assign o_upd_ready = (state_q == ST_IDLE);
   assign xfer        = i_upd_valid & o_upd_ready;

   assign payload = '{
      px: i_px, py: i_py,
      p0_x: i_p0_x, p0_y: i_p0_y, p0_w: i_p0_w,
      p1_x: i_p1_x, p1_y: i_p1_y, p1_w: i_p1_w,
      go: i_game_over
   };

   // Vsync history for the falling-edge frame-start detector.
   always_ff @(posedge clk_vga) begin
      if (rst_vga) vs_q <= 1'b1;
      else         vs_q <= i_vs;
   end

   // Frame counter drives the game-over blink.
   always_ff @(posedge clk_vga) begin
      if (rst_vga)      frame_cnt_q <= '0;
      else if (frm_sof) frame_cnt_q <= frame_cnt_q + 6'd1;
   end

   // Handshake FSM: take one word while idle, publish it at the next frame start.
   // A word accepted on the frame-start cycle itself waits for the following one.
   always_comb begin
      state_d  = state_q;
      stage_d  = stage_q;
      active_d = active_q;
      case (state_q)
         ST_IDLE: begin
            if (xfer) begin
               stage_d = payload;
               state_d = ST_PENDING;
            end
         end
         ST_PENDING: begin
            if (frm_sof) begin
               active_d = stage_q;
               state_d  = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State, staging and active scene registers.
   always_ff @(posedge clk_vga) begin
      if (rst_vga) begin
         state_q  <= ST_IDLE;
         stage_q  <= '0;
         active_q <= ACTIVE_RST;
      end else begin
         state_q  <= state_d;
         stage_q  <= stage_d;
         active_q <= active_d;
      end
   end

   logic                       player_hit;
   logic                       player_vis;
   logic [1:0][COORD_W-1:0]    plat_x;
   logic [1:0][COORD_W-1:0]    plat_y;
   logic [1:0][SIZE_W-1:0]     plat_w;
   logic [1:0]                 plat_hit;

   assign plat_x = {active_q.p1_x, active_q.p0_x};
   assign plat_y = {active_q.p1_y, active_q.p0_y};
   assign plat_w = {active_q.p1_w, active_q.p0_w};

   rect_hit u_player (
      .x   (i_x),
      .y   (i_y),
      .rx  (active_q.px),
      .ry  (active_q.py),
      .rw  (SIZE_W'(PLAYER_W)),
      .rh  (SIZE_W'(PLAYER_W)),
      .hit (player_hit)
   );

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_plat
         rect_hit u_plat (
            .x   (i_x),
            .y   (i_y),
            .rx  (plat_x[gi]),
            .ry  (plat_y[gi]),
            .rw  (plat_w[gi]),
            .rh  (SIZE_W'(PLAT_H)),
            .hit (plat_hit[gi])
         );
      end
   endgenerate

   assign player_vis = player_hit & ~(active_q.go & frame_cnt_q[BLINK_BIT]);

   rgb_t pix;

   // Priority mux: player over platforms over ground over sky.
   always_comb begin
      pix = COL_SKY;
      if (player_vis)
         pix = COL_PLAYER;
      else if (|plat_hit)
         pix = COL_PLAT;
      else if ({1'b0, i_y} >= (COORD_W+1)'(GROUND_Y))
         pix = COL_GROUND;
   end

   assign o_r = pix.r;
   assign o_g = pix.g;
   assign o_b = pix.b;

endmodule

// File: tb/tb_jump_scene_renderer.sv
// Self-checking bench for jump_scene_renderer: pixel tables plus handshake/frame sequences.
module tb_jump_scene_renderer;

   localparam logic [11:0] SKY = 12'h39F;
   localparam logic [11:0] GND = 12'h840;
   localparam logic [11:0] PLY = 12'hFF0;
   localparam logic [11:0] PLT = 12'h0C0;

   logic       clk_vga = 1'b0;
   logic       rst_vga = 1'b1;
   logic [9:0] i_x = '0, i_y = '0;
   logic       i_vs = 1'b1;
   logic       i_upd_valid = 1'b0;
   logic       o_upd_ready;
   logic [9:0] i_px = '0, i_py = '0;
   logic [9:0] i_p0_x = '0, i_p0_y = '0, i_p1_x = '0, i_p1_y = '0;
   logic [7:0] i_p0_w = '0, i_p1_w = '0;
   logic       i_game_over = 1'b0;
   logic [3:0] o_r, o_g, o_b;

   jump_scene_renderer dut (
      .clk_vga     (clk_vga),
      .rst_vga     (rst_vga),
      .i_x         (i_x),
      .i_y         (i_y),
      .i_vs        (i_vs),
      .i_upd_valid (i_upd_valid),
      .o_upd_ready (o_upd_ready),
      .i_px        (i_px),
      .i_py        (i_py),
      .i_p0_x      (i_p0_x),
      .i_p0_y      (i_p0_y),
      .i_p0_w      (i_p0_w),
      .i_p1_x      (i_p1_x),
      .i_p1_y      (i_p1_y),
      .i_p1_w      (i_p1_w),
      .i_game_over (i_game_over),
      .o_r         (o_r),
      .o_g         (o_g),
      .o_b         (o_b)
   );

   always #5 clk_vga = ~clk_vga;

   int errors = 0;
   int checks = 0;
   int fc = 0;               // expected frame counter
   logic [11:0] exp_q[$];    // scoreboard of expected pixel colours

   typedef struct {
      int          x;
      int          y;
      logic [11:0] rgb;
   } vec_t;
   vec_t tbl[$];

   task automatic check_pix(input int x, input int y, input logic [11:0] exp, input string name);
      logic [11:0] e;
      logic [11:0] act;
      exp_q.push_back(exp);
      i_x = 10'(x);
      i_y = 10'(y);
      #2;
      e   = exp_q.pop_front();
      act = {o_r, o_g, o_b};
      checks++;
      if (act !== e) begin
         errors++;
         $display("FAIL %s pix(%0d,%0d): got %h expected %h", name, x, y, act, e);
      end else
         $display("ok   %s pix(%0d,%0d) = %h", name, x, y, act);
   endtask

   task automatic check_rdy(input logic exp, input string name);
      checks++;
      if (o_upd_ready !== exp) begin
         errors++;
         $display("FAIL %s ready: got %b expected %b", name, o_upd_ready, exp);
      end else
         $display("ok   %s ready = %b", name, o_upd_ready);
   endtask

   task automatic run_tbl(input string name);
      foreach (tbl[i]) check_pix(tbl[i].x, tbl[i].y, tbl[i].rgb, name);
      tbl.delete();
   endtask

   task automatic set_payload(input int px, input int py,
                              input int p0x, input int p0y, input int p0w,
                              input int p1x, input int p1y, input int p1w, input logic go);
      i_px = 10'(px);   i_py = 10'(py);
      i_p0_x = 10'(p0x); i_p0_y = 10'(p0y); i_p0_w = 8'(p0w);
      i_p1_x = 10'(p1x); i_p1_y = 10'(p1y); i_p1_w = 8'(p1w);
      i_game_over = go;
   endtask

   // One valid cycle against an idle renderer; ready must drop right after.
   task automatic post(input string name);
      @(negedge clk_vga);
      #2;
      check_rdy(1'b1, {name, "_before"});
      i_upd_valid = 1'b1;
      @(posedge clk_vga);
      #1;
      check_rdy(1'b0, {name, "_after"});
      @(negedge clk_vga);
      i_upd_valid = 1'b0;
   endtask

   // Falling then rising vsync; exactly one frame start at the first posedge.
   task automatic frame_start();
      @(negedge clk_vga);
      i_vs = 1'b0;
      @(negedge clk_vga);
      i_vs = 1'b1;
      fc = (fc + 1) % 64;
      @(negedge clk_vga);
   endtask

   initial begin
      // ---------------- reset ----------------
      repeat (3) @(negedge clk_vga);
      rst_vga = 1'b0;
      #2;
      check_rdy(1'b1, "reset");
      tbl.push_back('{0, 0, SKY});
      tbl.push_back('{320, 460, GND});
      tbl.push_back('{312, 424, PLY});
      tbl.push_back('{327, 439, PLY});
      tbl.push_back('{328, 439, SKY});
      tbl.push_back('{311, 424, SKY});
      tbl.push_back('{312, 423, SKY});
      tbl.push_back('{0, 440, GND});
      tbl.push_back('{0, 439, SKY});
      tbl.push_back('{639, 479, GND});
      run_tbl("reset_scene");

      // ---------------- update mid-frame ----------------
      set_payload(100, 200, 0, 0, 0, 0, 0, 0, 1'b0);
      post("upd1");
      check_pix(100, 200, SKY, "upd1_pending");
      // Producer keeps valid asserted with a different word: must not be taken.
      set_payload(400, 200, 0, 0, 0, 0, 0, 0, 1'b0);
      i_upd_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk_vga);
         #2;
         check_rdy(1'b0, "hold_valid");
      end
      i_upd_valid = 1'b0;
      check_pix(100, 200, SKY, "upd1_still_pending");
      check_pix(312, 424, PLY, "upd1_old_player");
      frame_start();
      check_rdy(1'b1, "upd1_committed");
      tbl.push_back('{100, 200, PLY});
      tbl.push_back('{115, 215, PLY});
      tbl.push_back('{400, 200, SKY});
      tbl.push_back('{312, 424, SKY});
      run_tbl("upd1_commit");

      // ---------------- transfer coincident with frame start ----------------
      set_payload(200, 100, 0, 0, 0, 0, 0, 0, 1'b0);
      @(negedge clk_vga);
      i_upd_valid = 1'b1;
      i_vs = 1'b0;
      @(posedge clk_vga);
      #1;
      check_rdy(1'b0, "sof_xfer");
      fc = (fc + 1) % 64;
      @(negedge clk_vga);
      i_upd_valid = 1'b0;
      i_vs = 1'b1;
      repeat (4) @(negedge clk_vga);
      check_pix(200, 100, SKY, "sof_xfer_held_new");
      check_pix(100, 200, PLY, "sof_xfer_held_old");
      frame_start();
      check_rdy(1'b1, "sof_xfer_second");
      check_pix(200, 100, PLY, "sof_xfer_new");
      check_pix(100, 200, SKY, "sof_xfer_old_gone");

      // ---------------- platform at right edge ----------------
      set_payload(0, 0, 630, 300, 40, 0, 0, 0, 1'b0);
      post("plat_edge");
      frame_start();
      tbl.push_back('{639, 300, PLT});
      tbl.push_back('{630, 300, PLT});
      tbl.push_back('{629, 300, SKY});
      tbl.push_back('{5, 300, SKY});
      tbl.push_back('{639, 307, PLT});
      tbl.push_back('{639, 308, SKY});
      tbl.push_back('{639, 299, SKY});
      tbl.push_back('{15, 15, PLY});
      run_tbl("plat_edge");
      set_payload(0, 0, 630, 300, 0, 0, 0, 0, 1'b0);
      post("plat_hide");
      frame_start();
      check_pix(630, 300, SKY, "plat_hidden");

      // ---------------- player over platform, then game-over blink ----------------
      set_payload(100, 300, 0, 0, 0, 90, 300, 50, 1'b0);
      post("overlap");
      frame_start();
      tbl.push_back('{100, 300, PLY});
      tbl.push_back('{95, 300, PLT});
      tbl.push_back('{90, 307, PLT});
      tbl.push_back('{115, 315, PLY});
      tbl.push_back('{116, 300, PLT});
      tbl.push_back('{139, 300, PLT});
      tbl.push_back('{140, 300, SKY});
      run_tbl("overlap");
      set_payload(100, 300, 0, 0, 0, 90, 300, 50, 1'b1);
      post("game_over");
      frame_start();
      for (int f = 0; f < 70; f++) begin
         if (fc[4]) check_pix(100, 300, PLT, $sformatf("blink_fc%0d", fc));
         else       check_pix(100, 300, PLY, $sformatf("blink_fc%0d", fc));
         frame_start();
      end

      // ---------------- reset while pending ----------------
      set_payload(500, 100, 0, 0, 0, 0, 0, 0, 1'b0);
      post("pre_reset");
      @(negedge clk_vga);
      rst_vga = 1'b1;
      @(negedge clk_vga);
      rst_vga = 1'b0;
      fc = 0;
      #2;
      check_rdy(1'b1, "reset_mid_pending");
      tbl.push_back('{312, 424, PLY});
      tbl.push_back('{95, 300, SKY});
      tbl.push_back('{0, 0, SKY});
      tbl.push_back('{320, 460, GND});
      run_tbl("reset_mid_pending");
      frame_start();
      check_rdy(1'b1, "reset_after_sof");
      check_pix(500, 100, SKY, "staged_word_lost");
      check_pix(312, 424, PLY, "reset_player_kept");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Global time bound so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "timeout");
   end

endmodule
